// File: rtl/match_round_controller.sv
// -----------------------------------------------------------------------------
// match_round_controller
//
// Top-level sequencer for the 8-square colour matching game. It walks the
// player through four selections per round (secim1, secim2, es1, es2),
// rejects illegal picks, compares colour pairs (secim1, es1) and
// (secim2, es2), keeps the permanent matched mask and score, holds the round
// result on screen for SHOW_CYCLES clocks and finally declares game over.
//
// Optional build macro: ROUND_LIMIT_EN
//   defined   -> the game also ends after MAX_ROUNDS completed rounds
//                (game_over=1, win=0 unless every square is matched)
//   undefined -> no round limit, round_cnt is informational only
//
// Ports
//   clk25MHz      system clock
//   rst_n         asynchronous active-low reset
//   btn_sel       raw select button level (asynchronous)
//   btn_restart   raw restart button level (asynchronous)
//   cur_pos       cursor square reported by the enabled step module
//   square_color  3-bit colour of square k on bits [3k+2:3k]
//   step          step code: 1..4 SEL_A..SEL_D, 5 CHECK, 6 SHOW, 7 DONE
//   secim1/secim2/es1/es2  latched selections
//   sel_valid     {es2, es1, secim2, secim1} latched this round
//   matched_mask  bit k set when square k is permanently matched
//   score         matched pairs, 0..4
//   round_cnt     completed rounds, saturating at 15
//   last_match    {pair B, pair A} result of the last CHECK, valid in SHOW
//   reject        one-cycle pulse on an illegal pick
//   game_over     level, set in DONE
//   win           level, set when all eight squares are matched
// -----------------------------------------------------------------------------
module match_round_controller #(
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned MAX_ROUNDS  = 8
) (
  input  logic        clk25MHz,
  input  logic        rst_n,
  input  logic        btn_sel,
  input  logic        btn_restart,
  input  logic [2:0]  cur_pos,
  input  logic [23:0] square_color,
  output logic [3:0]  step,
  output logic [2:0]  secim1,
  output logic [2:0]  secim2,
  output logic [2:0]  es1,
  output logic [2:0]  es2,
  output logic [3:0]  sel_valid,
  output logic [7:0]  matched_mask,
  output logic [2:0]  score,
  output logic [3:0]  round_cnt,
  output logic [1:0]  last_match,
  output logic        reject,
  output logic        game_over,
  output logic        win
);

  localparam logic [3:0] ST_SEL_A = 4'b0001;
  localparam logic [3:0] ST_SEL_B = 4'b0010;
  localparam logic [3:0] ST_SEL_C = 4'b0011;
  localparam logic [3:0] ST_SEL_D = 4'b0100;
  localparam logic [3:0] ST_CHECK = 4'b0101;
  localparam logic [3:0] ST_SHOW  = 4'b0110;
  localparam logic [3:0] ST_DONE  = 4'b0111;

  localparam int unsigned     CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button synchronisers: two flops against metastability plus a delayed copy
  // for rising-level detection, so a held button yields a single press.
  // ---------------------------------------------------------------------------
  logic sel_s1, sel_s2, sel_prev;
  logic rst_s1, rst_s2, rst_prev;
  logic sel_press, restart_press;

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1   <= 1'b0;
      sel_s2   <= 1'b0;
      sel_prev <= 1'b0;
      rst_s1   <= 1'b0;
      rst_s2   <= 1'b0;
      rst_prev <= 1'b0;
    end else begin
      sel_s1   <= btn_sel;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      rst_s1   <= btn_restart;
      rst_s2   <= rst_s1;
      rst_prev <= rst_s2;
    end
  end

  assign sel_press     = sel_s2 & ~sel_prev;
  assign restart_press = rst_s2 & ~rst_prev;

  // ---------------------------------------------------------------------------
  // Pick legality and pair evaluation
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] color_of(input logic [23:0] colors,
                                          input logic [2:0]  idx);
    return colors[int'(idx)*3 +: 3];
  endfunction

  logic       pick_illegal;
  logic       pair_a, pair_b;
  logic [1:0] sel_idx;
  logic [3:0] round_next;
  logic [2:0] score_inc;
  logic [7:0] hit_mask;

  // A square already chosen this round or already matched cannot be picked.
  assign pick_illegal = matched_mask[cur_pos]
                      | (sel_valid[0] && (secim1 == cur_pos))
                      | (sel_valid[1] && (secim2 == cur_pos))
                      | (sel_valid[2] && (es1    == cur_pos))
                      | (sel_valid[3] && (es2    == cur_pos));

  // SEL_A..SEL_D are codes 1..4, so code-1 indexes secim1, secim2, es1, es2.
  assign sel_idx = 2'(step - 4'd1);

  assign pair_a = (color_of(square_color, secim1) == color_of(square_color, es1));
  assign pair_b = (color_of(square_color, secim2) == color_of(square_color, es2));

  assign score_inc  = {2'b00, pair_a} + {2'b00, pair_b};
  assign round_next = (round_cnt == 4'hF) ? 4'hF : round_cnt + 4'd1;

  // NOTE: a default assignment at the top of a combinational block keeps
  // every path driven, so no latch is inferred.
  always_comb begin
    hit_mask = 8'h00;
    if (pair_a) hit_mask = hit_mask | (8'h01 << secim1) | (8'h01 << es1);
    if (pair_b) hit_mask = hit_mask | (8'h01 << secim2) | (8'h01 << es2);
  end

  // ---------------------------------------------------------------------------
  // Round sequencer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] show_cnt;

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      step         <= ST_SEL_A;
      secim1       <= 3'd0;
      secim2       <= 3'd0;
      es1          <= 3'd0;
      es2          <= 3'd0;
      sel_valid    <= 4'h0;
      matched_mask <= 8'h00;
      score        <= 3'd0;
      round_cnt    <= 4'd0;
      last_match   <= 2'b00;
      reject       <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
      show_cnt     <= '0;
    end else begin
      reject <= 1'b0;
      if (restart_press) begin
        // Synchronous equivalent of reset; takes priority over a select press.
        step         <= ST_SEL_A;
        secim1       <= 3'd0;
        secim2       <= 3'd0;
        es1          <= 3'd0;
        es2          <= 3'd0;
        sel_valid    <= 4'h0;
        matched_mask <= 8'h00;
        score        <= 3'd0;
        round_cnt    <= 4'd0;
        last_match   <= 2'b00;
        game_over    <= 1'b0;
        win          <= 1'b0;
        show_cnt     <= '0;
      end else begin
        case (step)
          ST_SEL_A, ST_SEL_B, ST_SEL_C, ST_SEL_D: begin
            if (sel_press) begin
              if (pick_illegal) begin
                reject <= 1'b1;
              end else begin
                case (sel_idx)
                  2'd0:    secim1 <= cur_pos;
                  2'd1:    secim2 <= cur_pos;
                  2'd2:    es1    <= cur_pos;
                  default: es2    <= cur_pos;
                endcase
                sel_valid[sel_idx] <= 1'b1;
                step               <= step + 4'd1;  // SEL_D + 1 is CHECK
              end
            end
          end

          ST_CHECK: begin
            matched_mask <= matched_mask | hit_mask;
            score        <= score + score_inc;
            last_match   <= {pair_b, pair_a};
            show_cnt     <= '0;
            step         <= ST_SHOW;
          end

          ST_SHOW: begin
            if (show_cnt == SHOW_LAST) begin
              round_cnt <= round_next;
              if (matched_mask == 8'hFF) begin
                win       <= 1'b1;
                game_over <= 1'b1;
                step      <= ST_DONE;
`ifdef ROUND_LIMIT_EN
              end else if (round_next == 4'(MAX_ROUNDS)) begin
                game_over <= 1'b1;
                step      <= ST_DONE;
`endif
              end else begin
                sel_valid  <= 4'h0;
                last_match <= 2'b00;
                step       <= ST_SEL_A;
              end
            end else begin
              show_cnt <= show_cnt + 1'b1;
            end
          end

          ST_DONE: begin
            // Terminal until reset or restart.
          end

          default: step <= ST_SEL_A;
        endcase
      end
    end
  end

endmodule
